// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - exhaustive N-bit stimulus sweep with 1-bit response check against a truth table
module truth_table_sweeper #(
    parameter int N  = 3,
    parameter int DW = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [DW-1:0]   dwell,
    input  logic            stop_on_fail,
    input  logic [2**N-1:0] expected,
    output logic [N-1:0]    pattern,
    input  logic            resp,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N:0]      err_count,
    output logic [N-1:0]    first_fail,
    output logic            fail_valid
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [DW-1:0]    d_lat;
    logic [DW-1:0]    hold;
    logic             sof_lat;
    logic [2**N-1:0]  exp_lat;
    logic             mismatch;
    logic [N:0]       err_next;
    logic             last_pattern;

    always_comb begin
        mismatch     = (resp != exp_lat[pattern]);
        err_next     = err_count + {{N{1'b0}}, mismatch};
        last_pattern = (pattern == {N{1'b1}});
    end

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            d_lat      <= '0;
            hold       <= '0;
            sof_lat    <= 1'b0;
            exp_lat    <= '0;
            pattern    <= '0;
            pass       <= 1'b0;
            err_count  <= '0;
            first_fail <= '0;
            fail_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    pattern <= '0;
                    if (start) begin
                        d_lat      <= dwell;
                        hold       <= dwell;
                        sof_lat    <= stop_on_fail;
                        exp_lat    <= expected;
                        err_count  <= '0;
                        first_fail <= '0;
                        fail_valid <= 1'b0;
                        pass       <= 1'b0;
                        state      <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (hold != '0) begin
                        hold <= hold - DW'(1);
                    end else begin
                        // Closing edge of this pattern's dwell window: sample and advance.
                        err_count <= err_next;
                        hold      <= d_lat;
                        if (mismatch && !fail_valid) begin
                            first_fail <= pattern;
                            fail_valid <= 1'b1;
                        end
                        if (last_pattern || (sof_lat && mismatch)) begin
                            state   <= S_DONE;
                            pattern <= '0;
                            pass    <= (err_next == '0);
                        end else begin
                            pattern <= pattern + N'(1);
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule
